// File: rtl/dmem_responder_if.sv
// CPU-to-data-memory request/response bus carried between the CPU (master) and dmem_responder (slave).
interface dmem_responder_if;
    logic        memread;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        ready;
    logic        err;

    modport master (
        output memread, memwrite, addr, writedata,
        input  readdata, ready, err
    );

    modport slave (
        input  memread, memwrite, addr, writedata,
        output readdata, ready, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Wait-state data memory responder: IDLE -> WAIT (WAIT+1 cycles) -> RESP one-cycle ready strobe.
// Optional MMIO (LED register at 0xFFFF0000, cycle counter at 0xFFFF0004) enabled by DMEM_MMIO_EN.
module dmem_responder #(
    parameter int unsigned AW   = 8,
    parameter int unsigned WAIT = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus,
    output logic             busy,
    output logic [31:0]      led
);
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CW    = (WAIT > 0) ? $clog2(WAIT + 1) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     addr_q, wdata_q;
    logic            rd_q, wr_q;
    logic            ready_q, err_q, busy_q;
    logic [31:0]     rdata_q;
    logic [31:0]     mem [DEPTH];

    logic            accept, finish;
    logic            misalign, conflict, in_range, is_led, is_cyc, bad, mem_we;
    logic [31:0]     mmio_data, resp_data;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; finish marks the edge that enters RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.memread || bus.memwrite) begin
                    accept  = 1'b1;
                    state_d = ST_WAIT;
                    cnt_d   = CW'(WAIT);
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    finish  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request is frozen at acceptance; later input changes are ignored
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else if (accept) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.writedata;
            rd_q    <= bus.memread;
            wr_q    <= bus.memwrite;
        end
    end

`ifdef DMEM_MMIO_EN
    localparam logic [31:0] LED_ADDR = 32'hFFFF_0000;
    localparam logic [31:0] CYC_ADDR = 32'hFFFF_0004;

    logic [31:0] led_q, cyc_q;

    assign is_led    = (addr_q == LED_ADDR);
    assign is_cyc    = (addr_q == CYC_ADDR);
    assign mmio_data = is_led ? led_q : cyc_q;
    assign led       = led_q;

    // LED register and free-running cycle counter; counter writes are dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q <= '0;
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (finish && wr_q && !bad && is_led) led_q <= wdata_q;
        end
    end
`else
    assign is_led    = 1'b0;
    assign is_cyc    = 1'b0;
    assign mmio_data = '0;
    assign led       = '0;
`endif

    // Decode of the latched request
    always_comb begin
        misalign  = (addr_q[1:0] != 2'b00);
        conflict  = rd_q && wr_q;
        in_range  = ((addr_q >> (AW + 2)) == 32'd0);
        bad       = misalign || conflict || !(in_range || is_led || is_cyc);
        mem_we    = finish && wr_q && !bad && in_range;
        resp_data = '0;
        if (!bad && !wr_q) begin
            if (is_led || is_cyc) resp_data = mmio_data;
            else                  resp_data = mem[addr_q[AW+1:2]];
        end
    end

    // Storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q[AW+1:2]] <= wdata_q;
    end

    // Registered response outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            ready_q <= finish;
            err_q   <= finish && bad;
            rdata_q <= finish ? resp_data : 32'd0;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign bus.ready    = ready_q;
    assign bus.err      = err_q;
    assign bus.readdata = rdata_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (AW=8, WAIT=2); MMIO checks follow DMEM_MMIO_EN.
module tb_dmem_responder;
    localparam int unsigned AW   = 8;
    localparam int unsigned WAIT = 2;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        busy;
    logic [31:0] led;

    dmem_responder_if bus ();

    dmem_responder #(.AW(AW), .WAIT(WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy),
        .led   (led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        chk_data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic        prev_ready = 1'b0;
    logic [31:0] last_rdata;
    int          last_rdy_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    endtask

    // Monitor: pops one expectation per ready strobe
    always @(negedge clk) begin
        if (reset) begin
            check("ready_not_consecutive", 32'(bus.ready && prev_ready), 32'd0);
            if (bus.ready === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("resp_err", 32'(bus.err), 32'(mon_e.err));
                    if (mon_e.chk_data) check("resp_data", bus.readdata, mon_e.data);
                end
            end else begin
                check("idle_readdata_zero", bus.readdata, 32'd0);
                check("idle_err_zero", 32'(bus.err), 32'd0);
            end
        end
        prev_ready = bus.ready;
    end

    // One request from idle; inputs are scrambled after acceptance
    task automatic req(input string name, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_data, input logic exp_err,
                       input logic chk_data);
        int n;
        sb.push_back('{exp_data, exp_err, chk_data});
        bus.memread   = rd;
        bus.memwrite  = wr;
        bus.addr      = a;
        bus.writedata = wd;
        @(posedge clk); #1;
        check({name, "_busy_wait"}, 32'(busy), 32'd1);
        bus.memread   = 1'b0;
        bus.memwrite  = 1'b0;
        bus.addr      = ~a;
        bus.writedata = ~wd;
        n = 0;
        while (bus.ready !== 1'b1 && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_latency"}, 32'(n), 32'(WAIT + 1));
        check({name, "_busy_resp"}, 32'(busy), 32'd1);
        last_rdata   = bus.readdata;
        last_rdy_cyc = cyc;
        @(posedge clk); #1;
        check({name, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int          k;
        int          rcyc[4];
        logic [31:0] r1;
        int          c1;
        bus.memread   = 1'b0;
        bus.memwrite  = 1'b0;
        bus.addr      = '0;
        bus.writedata = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_readdata", bus.readdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_led", led, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        req("wr_10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        req("rd_10", 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        req("rd_misalign", 1'b1, 1'b0, 32'h2, 32'h0, 32'h0, 1'b1, 1'b1);
        req("rdwr_both", 1'b1, 1'b1, 32'h10, 32'h11111111, 32'h0, 1'b1, 1'b1);
        req("rd_10_again", 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        req("wr_misalign", 1'b0, 1'b1, 32'h11, 32'h22222222, 32'h0, 1'b1, 1'b1);
        req("rd_10_third", 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);

        req("wr_0", 1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
        req("wr_oor", 1'b0, 1'b1, 32'h400, 32'h1, 32'h0, 1'b1, 1'b1);
        req("rd_0", 1'b1, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
        req("wr_top", 1'b0, 1'b1, 32'h3FC, 32'h0BADF00D, 32'h0, 1'b0, 1'b1);
        req("rd_top", 1'b1, 1'b0, 32'h3FC, 32'h0, 32'h0BADF00D, 1'b0, 1'b1);
        req("rd_oor_high", 1'b1, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 1'b1);

        // Reset during WAIT discards the pending write
        req("wr_20_zero", 1'b0, 1'b1, 32'h20, 32'h0, 32'h0, 1'b0, 1'b1);
        bus.memwrite  = 1'b1;
        bus.addr      = 32'h20;
        bus.writedata = 32'h12345678;
        @(posedge clk); #1;
        bus.memwrite  = 1'b0;
        @(posedge clk); #1;
        check("abort_in_wait", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_rst_busy", 32'(busy), 32'd0);
        check("abort_rst_ready", 32'(bus.ready), 32'd0);
        check("abort_rst_readdata", bus.readdata, 32'd0);
        k = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.ready === 1'b1) k++;
        end
        check("abort_no_ready", 32'(k), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        req("rd_20_after_abort", 1'b1, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 1'b1);

        // Held read: one acceptance per WAIT+3 cycles (WAIT+1 wait, RESP, IDLE bubble)
        for (int i = 0; i < 4; i++) sb.push_back('{32'hDEADBEEF, 1'b0, 1'b1});
        bus.memread = 1'b1;
        bus.addr    = 32'h10;
        k = 0;
        for (int t = 0; t < 40 && k < 4; t++) begin
            @(posedge clk); #1;
            if (bus.ready === 1'b1) begin
                rcyc[k] = cyc;
                k++;
                if (k == 4) bus.memread = 1'b0;
            end
        end
        bus.memread = 1'b0;
        check("held_ready_count", 32'(k), 32'd4);
        for (int i = 1; i < 4; i++) check("held_interval", 32'(rcyc[i] - rcyc[i-1]), 32'(WAIT + 3));
        @(posedge clk); #1;
        check("held_stop_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("held_no_reaccept", 32'(busy), 32'd0);

`ifdef DMEM_MMIO_EN
        req("wr_led", 1'b0, 1'b1, 32'hFFFF_0000, 32'hA5, 32'h0, 1'b0, 1'b1);
        check("led_value", led, 32'h0000_00A5);
        req("rd_led", 1'b1, 1'b0, 32'hFFFF_0000, 32'h0, 32'hA5, 1'b0, 1'b1);
        req("rd_cyc1", 1'b1, 1'b0, 32'hFFFF_0004, 32'h0, 32'h0, 1'b0, 1'b0);
        r1 = last_rdata;
        c1 = last_rdy_cyc;
        repeat (3) @(posedge clk);
        #1;
        req("rd_cyc2", 1'b1, 1'b0, 32'hFFFF_0004, 32'h0, 32'h0, 1'b0, 1'b0);
        check("cyc_delta", last_rdata - r1, 32'(last_rdy_cyc - c1));
        req("wr_cyc_ignored", 1'b0, 1'b1, 32'hFFFF_0004, 32'h5, 32'h0, 1'b0, 1'b1);
        check("led_kept", led, 32'h0000_00A5);
`else
        req("wr_led_off", 1'b0, 1'b1, 32'hFFFF_0000, 32'hA5, 32'h0, 1'b1, 1'b1);
        check("led_tied_zero", led, 32'h0);
        req("rd_cyc_off", 1'b1, 1'b0, 32'hFFFF_0004, 32'h0, 32'h0, 1'b1, 1'b1);
        r1 = 32'h0;
        c1 = 0;
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
